ifu_prefetch: RTL and testbench

Parametrised instruction fetch unit with a valid/ready memory request port, a registered prefetch FIFO and redirect (flush) support. It sits between the instruction memory interface and the decode stage. It generates sequential PCs from a reset vector, tolerates variable memory latency and decode back-pressure, and discards in-flight fetches when the execute stage redirects the PC.

---
 rtl/ifu_prefetch.sv | 149 ++++++++++++++
 tb/tb_ifu_prefetch.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: sequential PC generation, one outstanding valid/ready
// memory request, prefetch FIFO toward decode, and redirect-driven flush.
module ifu_prefetch #(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000,
   parameter int unsigned           FIFO_DEPTH = 4,
   parameter logic [DATA_WIDTH-1:0] NOP_INST   = 32'h0000_0013
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [ADDR_WIDTH-1:0] imem_req_addr,
   input  logic                  imem_resp_valid,
   input  logic [DATA_WIDTH-1:0] imem_resp_data,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  inst_valid,
   input  logic                  inst_ready,
   output logic [DATA_WIDTH-1:0] inst,
   output logic [ADDR_WIDTH-1:0] inst_pc
);

   localparam int unsigned           PTR_W     = $clog2(FIFO_DEPTH);
   localparam int unsigned           CNT_W     = PTR_W + 1;
   localparam logic [ADDR_WIDTH-1:0] PC_STEP   = ADDR_WIDTH'(DATA_WIDTH / 8);
   localparam logic [CNT_W-1:0]      DEPTH_CNT = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_FETCH,
      S_WAIT,
      S_DROP_REQ,
      S_DROP_WAIT
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [ADDR_WIDTH-1:0] stale_addr_q, stale_addr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [DATA_WIDTH-1:0] data_mem_q [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] pc_mem_q   [FIFO_DEPTH];

   logic fifo_empty;
   logic not_full;
   logic req_valid;
   logic req_hs;
   logic push;
   logic pop;

   assign fifo_empty = (count_q == '0);
   assign not_full   = (count_q < DEPTH_CNT);

   // Request valid depends only on registered state, so it cannot glitch with ready.
   assign req_valid      = !rst && ((state_q == S_DROP_REQ) || ((state_q == S_FETCH) && not_full));
   assign imem_req_valid = req_valid;
   assign imem_req_addr  = (state_q == S_DROP_REQ) ? stale_addr_q : pc_q;
   assign req_hs         = req_valid && imem_req_ready;

   assign inst_valid = !rst && !fifo_empty;
   assign inst       = fifo_empty ? NOP_INST : data_mem_q[rd_ptr_q];
   assign inst_pc    = fifo_empty ? '0 : pc_mem_q[rd_ptr_q];
   assign pop        = inst_valid && inst_ready;

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      stale_addr_d = stale_addr_q;
      push         = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            if (redirect_valid) begin
               if (req_hs) begin
                  state_d = S_DROP_WAIT;
               end else if (req_valid) begin
                  state_d      = S_DROP_REQ;
                  stale_addr_d = pc_q;
               end
            end else if (req_hs) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (redirect_valid) begin
               state_d = imem_resp_valid ? S_FETCH : S_DROP_WAIT;
            end else if (imem_resp_valid) begin
               push    = 1'b1;
               pc_d    = pc_q + PC_STEP;
               state_d = S_FETCH;
            end
         end
         S_DROP_REQ: begin
            if (imem_req_ready) state_d = S_DROP_WAIT;
         end
         S_DROP_WAIT: begin
            if (imem_resp_valid) state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
      if (redirect_valid) pc_d = redirect_pc;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (redirect_valid) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (push && !pop)      count_d = count_q + CNT_W'(1);
         else if (!push && pop) count_d = count_q - CNT_W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_FETCH;
         pc_q         <= RESET_PC;
         stale_addr_q <= RESET_PC;
         count_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         stale_addr_q <= stale_addr_d;
         count_q      <= count_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
      end
   end

   // NOTE: FIFO storage is not reset; count_q alone decides which entries are valid.
   always_ff @(posedge clk) begin
      if (push) begin
         data_mem_q[wr_ptr_q] <= imem_resp_data;
         pc_mem_q[wr_ptr_q]   <= pc_q;
      end
   end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch: a latency/stall-configurable memory model,
// a pop monitor checking decode output against a scoreboard queue.
module tb_ifu_prefetch;

   localparam logic [31:0] PAT = 32'hA5A5_A5A5;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst;
   logic [31:0] inst_pc;

   exp_t        exp_q[$];
   logic [31:0] req_log[$];
   int          pop_cycles[$];
   int          pop_count = 0;
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          lat = 1;
   int          stall_left = 0;
   bit          mem_busy = 1'b0;
   int          mem_cnt = 0;
   logic [31:0] mem_addr = '0;

   ifu_prefetch dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_resp_valid(imem_resp_valid),
      .imem_resp_data (imem_resp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [31:0] pc);
      exp_q.push_back('{pc: pc, data: pc ^ PAT});
   endtask

   function automatic logic [31:0] get_req(input int k);
      if (k < req_log.size()) return req_log[k];
      return 'x;
   endfunction

   task automatic wait_pops(input int n, input string tag);
      int budget = 300;
      while (pop_count < n && budget > 0) begin
         tick();
         budget--;
      end
      check({tag, "_pop_timeout"}, pop_count >= n, 1);
   endtask

   task automatic wait_reqs(input int n, input string tag);
      int budget = 300;
      while (req_log.size() < n && budget > 0) begin
         tick();
         budget--;
      end
      check({tag, "_req_timeout"}, req_log.size() >= n, 1);
   endtask

   // Leaves rst high at posedge+1; the caller configures and then releases it.
   task automatic do_reset(input int n);
      tick();
      rst            = 1'b1;
      inst_ready     = 1'b0;
      redirect_valid = 1'b0;
      repeat (n) tick();
      req_log.delete();
      pop_cycles.delete();
   endtask

   // Memory model: ready (with optional stall), response lat cycles after handshake.
   initial begin
      forever begin
         @(negedge clk);
         imem_resp_valid = 1'b0;
         if (rst) begin
            mem_busy       = 1'b0;
            imem_req_ready = 1'b0;
         end else begin
            if (mem_busy) begin
               if (mem_cnt <= 1) begin
                  imem_resp_valid = 1'b1;
                  imem_resp_data  = mem_addr ^ PAT;
                  mem_busy        = 1'b0;
               end else begin
                  mem_cnt--;
               end
            end
            if (imem_req_valid && stall_left > 0) begin
               imem_req_ready = 1'b0;
               stall_left--;
            end else begin
               imem_req_ready = 1'b1;
            end
            if (imem_req_valid && imem_req_ready) begin
               mem_busy = 1'b1;
               mem_cnt  = lat;
               mem_addr = imem_req_addr;
               req_log.push_back(imem_req_addr);
            end
         end
      end
   end

   // Decode-side monitor: every accepted word is checked against the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && inst_valid && inst_ready) begin
            pop_count++;
            pop_cycles.push_back(cyc);
            check("sb_has_entry", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("inst_pc", inst_pc, e.pc);
               check("inst", inst, e.data);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;

      // Reset values, then first request at the reset vector.
      do_reset(3);
      sample();
      check("rst_req_valid", imem_req_valid, 0);
      check("rst_inst_valid", inst_valid, 0);
      check("rst_inst", inst, NOP);
      check("rst_inst_pc", inst_pc, 0);
      tick();
      rst        = 1'b0;
      inst_ready = 1'b1;
      for (int i = 0; i < 6; i++) push_exp(32'h8000_0000 + 32'(4 * i));
      sample();
      check("first_req_valid", imem_req_valid, 1);
      check("first_req_addr", imem_req_addr, 32'h8000_0000);
      wait_pops(6, "stream");
      for (int i = 1; i < pop_cycles.size() && i < 6; i++)
         check("throughput_gap", pop_cycles[i] - pop_cycles[i-1], 2);
      inst_ready = 1'b0;

      // Back-pressure: FIFO fills with exactly FIFO_DEPTH requests.
      do_reset(2);
      lat = 1;
      rst = 1'b0;
      for (int i = 0; i < 5; i++) push_exp(32'h8000_0000 + 32'(4 * i));
      repeat (16) tick();
      sample();
      check("bp_req_valid", imem_req_valid, 0);
      check("bp_req_count", req_log.size(), 4);
      check("bp_inst_valid", inst_valid, 1);
      check("bp_head_pc", inst_pc, 32'h8000_0000);
      check("bp_head_inst", inst, 32'h8000_0000 ^ PAT);
      tick();
      base       = pop_count;
      inst_ready = 1'b1;
      wait_pops(base + 5, "bp");
      inst_ready = 1'b0;
      check("bp_next_req", get_req(4), 32'h8000_0010);

      // Redirect while waiting on a 3-cycle response.
      do_reset(2);
      lat = 3;
      rst = 1'b0;
      wait_reqs(2, "rw");
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_1000;
      tick();
      redirect_valid = 1'b0;
      sample();
      check("rw_flush_inst_valid", inst_valid, 0);
      check("rw_drop_req_valid", imem_req_valid, 0);
      push_exp(32'h8000_1000);
      tick();
      base       = pop_count;
      inst_ready = 1'b1;
      wait_pops(base + 1, "rw");
      inst_ready = 1'b0;
      check("rw_target_req", get_req(2), 32'h8000_1000);

      // Redirect while the request is stalled; address must stay put.
      do_reset(2);
      lat        = 1;
      stall_left = 4;
      rst        = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) begin
            tick();
            redirect_valid = (i == 1);
            redirect_pc    = 32'h8000_2000;
         end
         sample();
         check("stall_req_valid", imem_req_valid, 1);
         check("stall_req_addr", imem_req_addr, 32'h8000_0000);
      end
      tick();
      redirect_valid = 1'b0;
      push_exp(32'h8000_2000);
      base       = pop_count;
      inst_ready = 1'b1;
      wait_pops(base + 1, "stall");
      inst_ready = 1'b0;
      check("stall_stale_req", get_req(0), 32'h8000_0000);
      check("stall_target_req", get_req(1), 32'h8000_2000);

      // Redirect to the top of the address space in the handshake cycle.
      do_reset(2);
      lat            = 1;
      rst            = 1'b0;
      inst_ready     = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      push_exp(32'hFFFF_FFFC);
      push_exp(32'h0000_0000);
      base = pop_count;
      tick();
      redirect_valid = 1'b0;
      wait_pops(base + 2, "wrap");
      inst_ready = 1'b0;
      check("wrap_req0", get_req(0), 32'h8000_0000);
      check("wrap_req1", get_req(1), 32'hFFFF_FFFC);
      check("wrap_req2", get_req(2), 32'h0000_0000);

      // Redirect coinciding with a response and a decode pop.
      do_reset(2);
      lat = 1;
      rst = 1'b0;
      wait_reqs(3, "coin");
      push_exp(32'h8000_0000);
      base           = pop_count;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_3000;
      inst_ready     = 1'b1;
      tick();
      redirect_valid = 1'b0;
      sample();
      check("coin_pop_count", pop_count, base + 1);
      check("coin_inst_valid", inst_valid, 0);
      check("coin_req_valid", imem_req_valid, 1);
      check("coin_req_addr", imem_req_addr, 32'h8000_3000);
      push_exp(32'h8000_3000);
      wait_pops(base + 2, "coin");
      inst_ready = 1'b0;

      check("sb_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
